vend_change_dispenser: RTL and testbench
========================================

// Module: vend_change_dispenser
//
// PURPOSE
//   Output end of the vending machine's coin path: takes the credit accumulated by the
//   coin-acceptor FSM, issues the vend strobe, then pays change or refunds one coin at a time.
//   Coins go out over a valid/ready handshake to the coin hopper, greedy largest coin first.
//   Sits between the credit-accumulation FSM (upstream) and the hopper/product latch (downstream).
//   Coin codes match the acceptor's input: 2'b01 nickel, 2'b10 dime, 2'b11 quarter, 2'b00 none.
//
// PARAMETERS
//   CW     4  width of credit/remaining counters, in nickels (5c units)
//   PRICE  5  product price in nickels (must be < 2**CW)
//
// PORTS
//   clk           in   1   single system clock, rising edge
//   rst_n         in   1   asynchronous, active-low reset
//   req_vend      in   1   1-cycle request: vend if credit_in >= PRICE, else refund all
//   req_refund    in   1   1-cycle request: refund all credit_in, no vend
//   credit_in     in   CW  credit in nickels, sampled with req_*
//   quarter_empty in   1   hopper has no quarters
//   dime_empty    in   1   hopper has no dimes (nickel supply is never empty)
//   coin_ready    in   1   hopper accepts the coin offered this cycle
//   coin_valid    out  1   coin_code is valid
//   coin_code     out  2   coin being dispensed
//   vend          out  1   1-cycle product-release strobe
//   busy          out  1   transaction in progress; new requests are ignored
//   done          out  1   1-cycle end-of-transaction strobe
//
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, remaining=0; every output 0.
//   All outputs are registered; no combinational path from an input to an output.
//   States: IDLE, VEND, CHANGE, OFFER, DONE.
//   IDLE:
//     - req_refund=1 (wins over req_vend): remaining<=credit_in, go to CHANGE.
//     - Else req_vend=1 and credit_in>=PRICE: remaining<=credit_in-PRICE, go to VEND.
//     - Else req_vend=1 and credit_in<PRICE: remaining<=credit_in, go to CHANGE (refund, vend stays 0).
//   VEND: vend=1 for exactly this cycle, then go to CHANGE.
//   CHANGE:
//     - remaining==0: go to DONE.
//     - Else select the coin:
//         remaining>=5 & !quarter_empty -> quarter
//         else remaining>=2 & !dime_empty -> dime
//         else nickel
//     - Register coin_code, set coin_valid, go to OFFER.
//   OFFER:
//     - coin_valid=1; coin_code is held stable until the transfer (coin_valid & coin_ready).
//     - On transfer: remaining -= value (Q=5, D=2, N=1), coin_valid<=0, coin_code<=00, go to CHANGE.
//     - No transfer: stay in OFFER, nothing changes.
//     - Result is one idle cycle between consecutive coins.
//   DONE: done=1 for exactly this cycle, then go to IDLE.
//   busy=1 in every state except IDLE. req_* while busy are dropped, never queued.
//   Subtraction never underflows: coin selection guarantees value <= remaining.
//   remaining is CW bits; 0 is only reached via the DONE path.
//   quarter_empty/dime_empty are sampled only in CHANGE. A change while in OFFER does not alter the offered coin.
//   Reset mid-transaction: all outputs drop immediately and the remaining credit is discarded.
//   Latency: req sampled at edge k -> vend high in cycle k+1 -> first coin_valid in cycle k+3.
//   With no change due, done is high in cycle k+3.
//
// TESTING
//   1. PRICE=5, credit_in=9, req_vend, coin_ready=1:
//      vend 1 cycle; coins dime, dime; done; vend asserted once.
//   2. credit_in=5, req_vend:
//      vend in cycle k+1, no coin_valid, done in cycle k+3, busy low after.
//   3. credit_in=3, req_vend:
//      vend never asserted; refund dime then nickel; done.
//   4. credit_in=15, req_vend: change quarter, quarter.
//      Repeat with quarter_empty=1: change is 5 dimes.
//      Repeat with both empty: change is 10 nickels.
//   5. Hold coin_ready=0 for 10 cycles during OFFER:
//      coin_valid and coin_code stable, busy=1, no extra coins.
//      Release: exactly one transfer counted.
//   6. Assert req_vend and req_refund together with credit_in=7: refund wins (quarter, dime), no vend.
//      Also pull rst_n low mid-OFFER: outputs 0 at once; after release, a fresh req_vend is served normally.

Source files
------------

// File: rtl/vend_change_dispenser.sv
// Vending machine output stage: issues the vend strobe for a paid product, then pays
// change (or refunds) one coin at a time over a valid/ready handshake, largest coin first.
module vend_change_dispenser #(
  parameter int CW    = 4,
  parameter int PRICE = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_vend,
  input  logic          req_refund,
  input  logic [CW-1:0] credit_in,
  input  logic          quarter_empty,
  input  logic          dime_empty,
  input  logic          coin_ready,
  output logic          coin_valid,
  output logic [1:0]    coin_code,
  output logic          vend,
  output logic          busy,
  output logic          done
);

  // state  | meaning
  // IDLE   | waiting for req_vend / req_refund
  // VEND   | vend strobe high for one cycle
  // CHANGE | pick next coin from remaining credit, or finish when nothing is left
  // OFFER  | coin offered to the hopper, waiting for coin_ready
  // DONE   | done strobe high for one cycle
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEND   = 3'd1,
    CHANGE = 3'd2,
    OFFER  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] VAL_Q   = CW'(5);
  localparam logic [CW-1:0] VAL_D   = CW'(2);
  localparam logic [CW-1:0] VAL_N   = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          coin_valid_q, coin_valid_d;
  logic [1:0]    coin_code_q, coin_code_d;
  logic          vend_q, vend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [1:0]    coin_sel;
  logic [CW-1:0] coin_val;

  always_comb begin
    if (rem_q >= VAL_Q && !quarter_empty)   coin_sel = COIN_QUARTER;
    else if (rem_q >= VAL_D && !dime_empty) coin_sel = COIN_DIME;
    else                                    coin_sel = COIN_NICKEL;
  end

  always_comb begin
    case (coin_code_q)
      COIN_QUARTER: coin_val = VAL_Q;
      COIN_DIME:    coin_val = VAL_D;
      default:      coin_val = VAL_N;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    coin_valid_d = coin_valid_q;
    coin_code_d  = coin_code_q;
    vend_d       = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_refund) begin
          rem_d   = credit_in;
          state_d = CHANGE;
        end else if (req_vend) begin
          if (credit_in >= PRICE_C) begin
            rem_d   = credit_in - PRICE_C;
            vend_d  = 1'b1;
            state_d = VEND;
          end else begin
            rem_d   = credit_in;
            state_d = CHANGE;
          end
        end
      end
      VEND: state_d = CHANGE;
      CHANGE: begin
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          coin_valid_d = 1'b1;
          coin_code_d  = coin_sel;
          state_d      = OFFER;
        end
      end
      OFFER: begin
        // coin selection guarantees coin_val <= rem_q, so no underflow here
        if (coin_valid_q && coin_ready) begin
          rem_d        = rem_q - coin_val;
          coin_valid_d = 1'b0;
          coin_code_d  = COIN_NONE;
          state_d      = CHANGE;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d      = IDLE;
        rem_d        = '0;
        coin_valid_d = 1'b0;
        coin_code_d  = COIN_NONE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      coin_valid_q <= 1'b0;
      coin_code_q  <= COIN_NONE;
      vend_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      coin_valid_q <= coin_valid_d;
      coin_code_q  <= coin_code_d;
      vend_q       <= vend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_code  = coin_code_q;
  assign vend       = vend_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for vend_change_dispenser (PRICE=5, CW=4): coin sequences, strobe
// latency, handshake back-pressure, request priority and mid-transaction reset.
module tb_vend_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_vend = 1'b0;
  logic       req_refund = 1'b0;
  logic [3:0] credit_in = 4'd0;
  logic       quarter_empty = 1'b0;
  logic       dime_empty = 1'b0;
  logic       coin_ready = 1'b1;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       vend;
  logic       busy;
  logic       done;

  vend_change_dispenser #(.CW(4), .PRICE(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_vend      (req_vend),
    .req_refund    (req_refund),
    .credit_in     (credit_in),
    .quarter_empty (quarter_empty),
    .dime_empty    (dime_empty),
    .coin_ready    (coin_ready),
    .coin_valid    (coin_valid),
    .coin_code     (coin_code),
    .vend          (vend),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // transaction monitor, sampled on the falling edge
  int n_coins, seq, vend_cnt, done_cnt, vend_cyc, done_cyc, first_cv_cyc;
  always @(negedge clk) begin
    if (coin_valid && first_cv_cyc < 0) first_cv_cyc = cyc;
    if (coin_valid && coin_ready) begin
      n_coins++;
      seq = seq * 4 + int'(coin_code);
    end
    if (vend) begin
      vend_cnt++;
      vend_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_coins = 0; seq = 0; vend_cnt = 0; done_cnt = 0;
    vend_cyc = -1; done_cyc = -1; first_cv_cyc = -1;
  endtask

  // drive a 1-cycle request; ek is the cycle count right after the sampling edge
  task automatic start(input logic [3:0] cr, input logic v, input logic r, output int ek);
    @(posedge clk); #1;
    clear_mon();
    credit_in = cr; req_vend = v; req_refund = r;
    @(posedge clk); #1;
    ek = cyc;
    req_vend = 1'b0; req_refund = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (coin_valid) begin seen = 1'b1; break; end
    end
    check_val({tag, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  int ek;
  logic [1:0] code0;
  bit stable;

  initial begin
    clear_mon();
    #1 rst_n = 1'b0;
    #2;
    check_val("reset_outputs", 32'({coin_valid, coin_code, vend, busy, done}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 9 nickels, vend: change 4 -> dime, dime
    start(4'd9, 1'b1, 1'b0, ek);
    wait_done("t1");
    check_val("t1_vend_cnt", 32'(vend_cnt), 32'd1);
    check_val("t1_vend_cyc", 32'(vend_cyc - ek), 32'd0);
    check_val("t1_first_coin_cyc", 32'(first_cv_cyc - ek), 32'd2);
    check_val("t1_n_coins", 32'(n_coins), 32'd2);
    check_val("t1_seq", 32'(seq), 32'b1010);
    check_val("t1_done_cnt", 32'(done_cnt), 32'd1);

    // exact price: no change, done two cycles after vend
    start(4'd5, 1'b1, 1'b0, ek);
    wait_done("t2");
    check_val("t2_vend_cyc", 32'(vend_cyc - ek), 32'd0);
    check_val("t2_done_cyc", 32'(done_cyc - ek), 32'd2);
    check_val("t2_no_coin", 32'(first_cv_cyc < 0), 32'd1);
    check_val("t2_busy_after", 32'(busy), 32'd0);

    // insufficient credit: refund dime, nickel
    start(4'd3, 1'b1, 1'b0, ek);
    wait_done("t3");
    check_val("t3_vend_cnt", 32'(vend_cnt), 32'd0);
    check_val("t3_seq", 32'(seq), 32'b1001);
    check_val("t3_n_coins", 32'(n_coins), 32'd2);

    // change of 10 nickels with varying hopper stock
    start(4'd15, 1'b1, 1'b0, ek);
    wait_done("t4a");
    check_val("t4a_n_coins", 32'(n_coins), 32'd2);
    check_val("t4a_seq", 32'(seq), 32'b1111);
    quarter_empty = 1'b1;
    start(4'd15, 1'b1, 1'b0, ek);
    wait_done("t4b");
    check_val("t4b_n_coins", 32'(n_coins), 32'd5);
    check_val("t4b_seq", 32'(seq), 32'b10_1010_1010);
    dime_empty = 1'b1;
    start(4'd15, 1'b1, 1'b0, ek);
    wait_done("t4c");
    check_val("t4c_n_coins", 32'(n_coins), 32'd10);
    check_val("t4c_seq", 32'(seq), 32'b0101_0101_0101_0101_0101);
    quarter_empty = 1'b0;
    dime_empty = 1'b0;

    // back-pressure: hopper stalls 10 cycles on the first coin
    coin_ready = 1'b0;
    start(4'd9, 1'b1, 1'b0, ek);
    wait_valid("t5");
    code0 = coin_code;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!coin_valid || coin_code !== code0 || !busy) stable = 1'b0;
    end
    check_val("t5_stable", 32'(stable), 32'd1);
    check_val("t5_held_code", 32'(code0), 32'd2);
    check_val("t5_no_transfer", 32'(n_coins), 32'd0);
    @(posedge clk); #1;
    coin_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("t5_one_transfer", 32'(n_coins), 32'd1);
    wait_done("t5");
    check_val("t5_n_coins", 32'(n_coins), 32'd2);
    check_val("t5_seq", 32'(seq), 32'b1010);

    // refund wins over vend
    start(4'd7, 1'b1, 1'b1, ek);
    wait_done("t6a");
    check_val("t6a_vend_cnt", 32'(vend_cnt), 32'd0);
    check_val("t6a_seq", 32'(seq), 32'b1110);
    check_val("t6a_n_coins", 32'(n_coins), 32'd2);

    // reset while a coin is on offer
    coin_ready = 1'b0;
    start(4'd9, 1'b1, 1'b0, ek);
    wait_valid("t6b");
    #2 rst_n = 1'b0;
    #1;
    check_val("t6b_reset_outputs", 32'({coin_valid, coin_code, vend, busy, done}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    coin_ready = 1'b1;
    start(4'd5, 1'b1, 1'b0, ek);
    wait_done("t6c");
    check_val("t6c_vend_cnt", 32'(vend_cnt), 32'd1);
    check_val("t6c_n_coins", 32'(n_coins), 32'd0);
    check_val("t6c_done_cyc", 32'(done_cyc - ek), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
